// File: rtl/wb_lbus_burst_master.sv
// Local-bus (Wishbone-style) burst master: one Stb/Ack handshake per beat, with
// address auto-increment, Err abort and Ack timeout.
module wb_lbus_burst_master #(
   parameter int unsigned WB_DATA_WIDTH = 16,
   parameter int unsigned WB_ADDR_WIDTH = 16,
   parameter int unsigned MAX_BURST     = 16,
   parameter int unsigned ADDR_INC      = 1,
   parameter int unsigned TIMEOUT_CYC   = 255
) (
   input  logic                         CLK_32,
   input  logic                         RESET_MKO,
   input  logic                         cmd_valid,
   output logic                         cmd_ready,
   input  logic                         cmd_we,
   input  logic [WB_ADDR_WIDTH-1:0]     cmd_adr,
   input  logic [$clog2(MAX_BURST)-1:0] cmd_len,
   input  logic                         wdat_valid,
   output logic                         wdat_ready,
   input  logic [WB_DATA_WIDTH-1:0]     wdat,
   output logic                         rdat_valid,
   input  logic                         rdat_ready,
   output logic [WB_DATA_WIDTH-1:0]     rdat,
   output logic                         done,
   output logic [1:0]                   status,
   output logic [WB_ADDR_WIDTH-1:0]     Adr_master_o_lbus,
   output logic [WB_DATA_WIDTH-1:0]     Dat_master_o_lbus,
   input  logic [WB_DATA_WIDTH-1:0]     Dat_master_i_lbus,
   output logic                         We_master_o_lbus,
   output logic                         Stb_master_o_lbus,
   input  logic                         Ack_master_i_lbus,
   input  logic                         Err_master_i_lbus
);

   localparam int unsigned LW = $clog2(MAX_BURST);
   localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);

   typedef enum logic [2:0] {StIdle, StWfetch, StStb, StRhold, StGap, StDone} state_t;

   state_t          state_q;
   logic            we_q;
   logic [LW-1:0]   left_q;   // beats remaining after the current one
   logic [TW-1:0]   tmo_q;
   logic            last_beat;

   assign last_beat = (left_q == '0);

   always_ff @(posedge CLK_32 or posedge RESET_MKO) begin
      if (RESET_MKO) begin
         state_q           <= StIdle;
         we_q              <= 1'b0;
         left_q            <= '0;
         tmo_q             <= '0;
         cmd_ready         <= 1'b1;
         wdat_ready        <= 1'b0;
         rdat_valid        <= 1'b0;
         rdat              <= '0;
         done              <= 1'b0;
         status            <= 2'b00;
         Adr_master_o_lbus <= '0;
         Dat_master_o_lbus <= '0;
         We_master_o_lbus  <= 1'b0;
         Stb_master_o_lbus <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state_q)
            StIdle: begin
               if (cmd_valid) begin
                  cmd_ready         <= 1'b0;
                  we_q              <= cmd_we;
                  Adr_master_o_lbus <= cmd_adr;
                  left_q            <= cmd_len;
                  if (cmd_we) begin
                     wdat_ready <= 1'b1;
                     state_q    <= StWfetch;
                  end else begin
                     Stb_master_o_lbus <= 1'b1;
                     We_master_o_lbus  <= 1'b0;
                     tmo_q             <= '0;
                     state_q           <= StStb;
                  end
               end
            end
            StWfetch: begin
               if (wdat_valid) begin
                  wdat_ready        <= 1'b0;
                  Dat_master_o_lbus <= wdat;
                  Stb_master_o_lbus <= 1'b1;
                  We_master_o_lbus  <= 1'b1;
                  tmo_q             <= '0;
                  state_q           <= StStb;
               end
            end
            StStb: begin
               // Err wins over a simultaneous Ack; Ack wins over an expiring timeout.
               if (Err_master_i_lbus) begin
                  Stb_master_o_lbus <= 1'b0;
                  We_master_o_lbus  <= 1'b0;
                  status            <= 2'b01;
                  done              <= 1'b1;
                  state_q           <= StDone;
               end else if (Ack_master_i_lbus) begin
                  Stb_master_o_lbus <= 1'b0;
                  if (!we_q) begin
                     rdat       <= Dat_master_i_lbus;
                     rdat_valid <= 1'b1;
                     state_q    <= StRhold;
                  end else if (last_beat) begin
                     We_master_o_lbus <= 1'b0;
                     status           <= 2'b00;
                     done             <= 1'b1;
                     state_q          <= StDone;
                  end else begin
                     state_q <= StGap;
                  end
               end else if (tmo_q == TW'(TIMEOUT_CYC - 1)) begin
                  Stb_master_o_lbus <= 1'b0;
                  We_master_o_lbus  <= 1'b0;
                  status            <= 2'b10;
                  done              <= 1'b1;
                  state_q           <= StDone;
               end else begin
                  tmo_q <= tmo_q + TW'(1);
               end
            end
            StRhold: begin
               if (rdat_ready) begin
                  rdat_valid <= 1'b0;
                  if (last_beat) begin
                     status  <= 2'b00;
                     done    <= 1'b1;
                     state_q <= StDone;
                  end else begin
                     state_q <= StGap;
                  end
               end
            end
            StGap: begin
               Adr_master_o_lbus <= Adr_master_o_lbus + WB_ADDR_WIDTH'(ADDR_INC);
               left_q            <= left_q - LW'(1);
               if (we_q) begin
                  wdat_ready <= 1'b1;
                  state_q    <= StWfetch;
               end else begin
                  Stb_master_o_lbus <= 1'b1;
                  tmo_q             <= '0;
                  state_q           <= StStb;
               end
            end
            StDone: begin
               We_master_o_lbus <= 1'b0;
               cmd_ready        <= 1'b1;
               state_q          <= StIdle;
            end
            default: state_q <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_wb_lbus_burst_master.sv
// Directed bench for wb_lbus_burst_master: transaction-level expectation queues checked every
// cycle on the falling edge, plus literal checks on each scenario.
module tb_wb_lbus_burst_master;

   localparam int DW  = 16;
   localparam int AW  = 16;
   localparam int LW  = 4;
   localparam int TMO = 8;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          cmd_valid, cmd_ready, cmd_we;
   logic [AW-1:0] cmd_adr;
   logic [LW-1:0] cmd_len;
   logic          wdat_valid, wdat_ready;
   logic [DW-1:0] wdat;
   logic          rdat_valid, rdat_ready;
   logic [DW-1:0] rdat;
   logic          done;
   logic [1:0]    status;
   logic [AW-1:0] adr_o;
   logic [DW-1:0] dat_o, dat_i;
   logic          we_o, stb_o, ack_i, err_i;

   always #5 clk = ~clk;

   wb_lbus_burst_master #(
      .WB_DATA_WIDTH(DW),
      .WB_ADDR_WIDTH(AW),
      .MAX_BURST    (16),
      .ADDR_INC     (1),
      .TIMEOUT_CYC  (TMO)
   ) dut (
      .CLK_32           (clk),
      .RESET_MKO        (rst),
      .cmd_valid        (cmd_valid),
      .cmd_ready        (cmd_ready),
      .cmd_we           (cmd_we),
      .cmd_adr          (cmd_adr),
      .cmd_len          (cmd_len),
      .wdat_valid       (wdat_valid),
      .wdat_ready       (wdat_ready),
      .wdat             (wdat),
      .rdat_valid       (rdat_valid),
      .rdat_ready       (rdat_ready),
      .rdat             (rdat),
      .done             (done),
      .status           (status),
      .Adr_master_o_lbus(adr_o),
      .Dat_master_o_lbus(dat_o),
      .Dat_master_i_lbus(dat_i),
      .We_master_o_lbus (we_o),
      .Stb_master_o_lbus(stb_o),
      .Ack_master_i_lbus(ack_i),
      .Err_master_i_lbus(err_i)
   );

   typedef struct packed {
      logic [AW-1:0] adr;
      logic          we;
      logic [DW-1:0] dat;
   } beat_t;

   beat_t         exp_beats[$];
   beat_t         cur;
   logic          have_cur = 1'b0;
   logic [DW-1:0] exp_rd[$];
   logic [1:0]    exp_st[$];
   logic [DW-1:0] wq[$];
   logic [DW-1:0] rd_data[16];

   int ack_delay = 0, err_beat = -1, silent = 0, stall_beat = -1, stall_left = 0;
   int s_cyc = 0, s_idx = 0, r_idx = 0;
   int stb_len = 0, last_stb_len = 0, n_beats = 0, n_done = 0, n_wfire = 0;
   logic          stb_prev = 1'b0;
   logic [AW-1:0] mon_adr = '0;
   logic [DW-1:0] mon_dat = '0;
   logic          w_fire = 1'b0, r_fire = 1'b0, c_fire = 1'b0;
   int total = 0, bad = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Falling-edge compare of DUT outputs against the expectation queues.
   task automatic sample();
      w_fire = wdat_valid && wdat_ready;
      r_fire = rdat_valid && rdat_ready;
      c_fire = cmd_valid && cmd_ready;
      if (w_fire) n_wfire++;
      if (stb_o) begin
         check("ready_low_in_stb", cmd_ready, 0);
         if (!stb_prev) begin
            n_beats++;
            stb_len = 0;
            mon_adr = adr_o;
            mon_dat = dat_o;
            check("stb_expected", exp_beats.size() != 0, 1);
            have_cur = (exp_beats.size() != 0);
            if (have_cur) cur = exp_beats.pop_front();
         end
         if (have_cur) begin
            check("stb_adr", adr_o, cur.adr);
            check("stb_we", we_o, cur.we);
            if (cur.we) check("stb_dat", dat_o, cur.dat);
         end
         stb_len++;
      end else if (stb_prev) begin
         last_stb_len = stb_len;
      end
      stb_prev = stb_o;
      if (r_fire) begin
         check("rdat_expected", exp_rd.size() != 0, 1);
         if (exp_rd.size() != 0) check("rdat", rdat, exp_rd.pop_front());
      end
      if (done) begin
         n_done++;
         check("done_expected", exp_st.size() != 0, 1);
         if (exp_st.size() != 0) check("status", status, exp_st.pop_front());
      end
   endtask

   // Drive inputs just after the rising edge: command, write producer, slave, read consumer.
   task automatic drive();
      if (c_fire) cmd_valid = 1'b0;
      if (w_fire && wq.size() != 0) void'(wq.pop_front());
      wdat_valid = (wq.size() != 0);
      wdat       = (wq.size() != 0) ? wq[0] : '0;
      ack_i = 1'b0;
      err_i = 1'b0;
      dat_i = '0;
      if (done || rst) s_idx = 0;
      if (stb_o && !rst) begin
         if (silent == 0 && s_cyc == ack_delay) begin
            ack_i = 1'b1;
            if (s_idx == err_beat) err_i = 1'b1;
            else dat_i = rd_data[s_idx];
            s_idx++;
         end
         s_cyc++;
      end else begin
         s_cyc = 0;
      end
      if (r_fire) r_idx++;
      if (rdat_valid && r_idx == stall_beat && stall_left > 0) begin
         rdat_ready = 1'b0;
         stall_left--;
      end else begin
         rdat_ready = 1'b1;
      end
   endtask

   task automatic tick();
      @(negedge clk);
      sample();
      @(posedge clk);
      #1;
      drive();
   endtask

   task automatic start_cmd(input logic we, input logic [AW-1:0] adr, input int len,
                            input int nb_exp, input logic [1:0] st);
      beat_t b;
      for (int i = 0; i < nb_exp; i++) begin
         b.adr = adr + AW'(i);
         b.we  = we;
         b.dat = we ? wq[i] : '0;
         exp_beats.push_back(b);
         if (!we && st == 2'b00) exp_rd.push_back(rd_data[i]);
      end
      exp_st.push_back(st);
      r_idx     = 0;
      cmd_valid = 1'b1;
      cmd_we    = we;
      cmd_adr   = adr;
      cmd_len   = LW'(len);
   endtask

   task automatic wait_done();
      int d0 = n_done;
      for (int i = 0; i < 300 && n_done == d0; i++) tick();
      check("done_seen", n_done - d0, 1);
      check("beats_left", exp_beats.size(), 0);
      check("rd_left", exp_rd.size(), 0);
      tick();
      check("ready_after_done", cmd_ready, 1);
   endtask

   initial begin
      int b0, w0, d0;
      cmd_valid  = 1'b0;
      cmd_we     = 1'b0;
      cmd_adr    = '0;
      cmd_len    = '0;
      wdat_valid = 1'b0;
      wdat       = '0;
      rdat_ready = 1'b1;
      dat_i      = '0;
      ack_i      = 1'b0;
      err_i      = 1'b0;
      for (int i = 0; i < 16; i++) rd_data[i] = '0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_cmd_ready", cmd_ready, 1);
      check("rst_stb", stb_o, 0);
      check("rst_done", done, 0);
      check("rst_status", status, 0);
      check("rst_wdat_ready", wdat_ready, 0);
      check("rst_rdat_valid", rdat_valid, 0);
      check("rst_adr", adr_o, 0);
      rst = 1'b0;

      // 1: single write
      wq = '{16'h0001};
      ack_delay = 2;
      start_cmd(1'b1, 16'hA000, 0, 1, 2'b00);
      wait_done();
      check("t1_stb_len", last_stb_len, 3);
      check("t1_adr", mon_adr, 16'hA000);
      check("t1_dat", mon_dat, 16'h0001);
      check("t1_status", status, 2'b00);

      // 2: four-beat write burst
      b0 = n_beats;
      wq = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
      ack_delay = 1;
      start_cmd(1'b1, 16'hA001, 3, 4, 2'b00);
      wait_done();
      check("t2_beats", n_beats - b0, 4);
      check("t2_last_adr", mon_adr, 16'hA004);
      check("t2_last_dat", mon_dat, 16'h4444);

      // 3: read burst wrapping the address, consumer stalls on beat 2
      b0 = n_beats;
      rd_data[0] = 16'h8001;
      rd_data[1] = 16'h8002;
      rd_data[2] = 16'h8003;
      ack_delay  = 0;
      stall_beat = 1;
      stall_left = 3;
      start_cmd(1'b0, 16'hFFFF, 2, 3, 2'b00);
      wait_done();
      check("t3_beats", n_beats - b0, 3);
      check("t3_last_adr", mon_adr, 16'h0001);
      check("t3_stall_used", stall_left, 0);
      stall_beat = -1;

      // 4: Err (with Ack) on beat 2 of a 4-beat write
      b0 = n_beats;
      w0 = n_wfire;
      wq = '{16'h5555, 16'h6666, 16'h7777, 16'h8888};
      err_beat = 1;
      start_cmd(1'b1, 16'h0100, 3, 2, 2'b01);
      wait_done();
      repeat (4) tick();
      check("t4_beats", n_beats - b0, 2);
      check("t4_wfires", n_wfire - w0, 2);
      check("t4_status_held", status, 2'b01);
      check("t4_wdat_ready", wdat_ready, 0);
      wq.delete();
      err_beat = -1;
      tick();

      // 5: silent slave times out after TMO strobe cycles
      silent = 1;
      start_cmd(1'b0, 16'h0200, 0, 1, 2'b10);
      wait_done();
      check("t5_stb_len", last_stb_len, TMO);
      check("t5_status", status, 2'b10);
      silent = 0;

      // 6: asynchronous reset during STB of a 4-beat read
      d0 = n_done;
      ack_delay = 5;
      start_cmd(1'b0, 16'h0300, 3, 4, 2'b00);
      for (int i = 0; i < 20 && !stb_o; i++) tick();
      check("t6_stb_seen", stb_o, 1);
      #3;
      rst = 1'b1;
      #1;
      check("t6_rst_stb", stb_o, 0);
      check("t6_rst_ready", cmd_ready, 1);
      check("t6_rst_we", we_o, 0);
      check("t6_rst_adr", adr_o, 0);
      check("t6_rst_status", status, 0);
      check("t6_rst_rvalid", rdat_valid, 0);
      exp_beats.delete();
      exp_rd.delete();
      exp_st.delete();
      repeat (2) tick();
      rst = 1'b0;
      check("t6_no_done", n_done - d0, 0);
      ack_delay  = 0;
      rd_data[0] = 16'h8004;
      start_cmd(1'b0, 16'h0400, 0, 1, 2'b00);
      wait_done();
      check("t6_after_adr", mon_adr, 16'h0400);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
